// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: Tuse/forward/mult-div codes and slot records.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

    // Tuse code meaning "this operand is not read"
    localparam logic [2:0] TUSE_NONE_DEF   = 3'd7;

    // Operand source encodings shared by the D, E and M muxes
    localparam logic [1:0] FWD_RF          = 2'd0;  // regfile / pipe register
    localparam logic [1:0] FWD_W           = 2'd1;
    localparam logic [1:0] FWD_M           = 2'd2;
    localparam logic [1:0] FWD_E           = 2'd3;

    // HI/LO unit operation classes
    localparam logic [1:0] MD_NONE         = 2'd0;
    localparam logic [1:0] MD_MULT         = 2'd1;
    localparam logic [1:0] MD_DIV          = 2'd2;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // In-flight writer in E; raddrs are kept so E-stage forwarding can be resolved
    typedef struct packed {
        logic [4:0] waddr;
        logic [2:0] tnew;
        logic [4:0] raddr0;
        logic [4:0] raddr1;
        logic [1:0] md;
    } slot_e_t;

    // M keeps raddr1 for store-data forwarding from W
    typedef struct packed {
        logic [4:0] waddr;
        logic [2:0] tnew;
        logic [4:0] raddr1;
    } slot_m_t;

    typedef struct packed {
        logic [4:0] waddr;
        logic [2:0] tnew;
    } slot_w_t;

    // One stage closer to producing the result; never wraps below zero
    function automatic logic [2:0] tnew_dec(input logic [2:0] tnew);
        return (tnew == 3'd0) ? 3'd0 : tnew - 3'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// HI/LO unit occupancy timer: loads when a mult/div sits in E, then counts down to zero.
// Latency: md_busy is combinational from the E-slot class and the registered counter.
// Backpressure: none; the consumer stalls D on md_busy.
// Ports: clk, reset (async active-low), e_md (class of the instruction in E), md_busy.
module md_busy_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] e_md,
    output logic       md_busy
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (e_md == MD_MULT) begin
            cnt_d = 4'(MULT_CYCLES);
        end else if (e_md == MD_DIV) begin
            cnt_d = 4'(DIV_CYCLES);
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The unit is already claimed while the op is still in E, before the counter loads
    assign md_busy = (cnt_q != 4'd0) || (e_md != MD_NONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks E/M/W writers, raises the D stall and drives all operand forward selects.
// Latency: stall and fwd_* are combinational from D inputs and registered slot state (zero cycles).
// Backpressure: stall holds PC and F/D and injects a bubble into D/E; HI/LO busy folds into the same stall.
// Ports: clk, reset (async active-low); D decode inputs d_*; outputs stall, fwd_d0/1, fwd_e0/1, fwd_m1, md_busy.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter logic [2:0]  TUSE_NONE   = TUSE_NONE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_raddr0,
    input  logic [4:0] d_raddr1,
    input  logic [2:0] d_tuse0,
    input  logic [2:0] d_tuse1,
    input  logic [4:0] d_waddr,
    input  logic [2:0] d_tnew,
    input  logic [1:0] d_md_start,
    input  logic       d_md_use,
    output logic       stall,
    output logic [1:0] fwd_d0,
    output logic [1:0] fwd_d1,
    output logic [1:0] fwd_e0,
    output logic [1:0] fwd_e1,
    output logic       fwd_m1,
    output logic       md_busy
);

    slot_e_t slot_e_q, slot_e_d;
    slot_m_t slot_m_q, slot_m_d;
    slot_w_t slot_w_q, slot_w_d;

    logic raw_stall;

    // A D operand must wait if a writer in E or M will still be producing its
    // value later than the operand is needed. W always has the result ready.
    function automatic logic raw_hazard(input logic [4:0] raddr,
                                        input logic [2:0] tuse,
                                        input slot_e_t    e,
                                        input slot_m_t    m);
        return (raddr != 5'd0) && (tuse != TUSE_NONE) &&
               (((e.waddr == raddr) && (e.tnew > tuse)) ||
                ((m.waddr == raddr) && (m.tnew > tuse)));
    endfunction

    // Youngest ready producer wins; raddr 0 can never match since waddr 0 is excluded
    function automatic logic [1:0] sel_d(input logic [4:0] raddr,
                                         input slot_e_t    e,
                                         input slot_m_t    m,
                                         input slot_w_t    w);
        logic [1:0] sel;
        sel = FWD_RF;
        if ((w.waddr != 5'd0) && (w.waddr == raddr) && (w.tnew == 3'd0)) sel = FWD_W;
        if ((m.waddr != 5'd0) && (m.waddr == raddr) && (m.tnew == 3'd0)) sel = FWD_M;
        if ((e.waddr != 5'd0) && (e.waddr == raddr) && (e.tnew == 3'd0)) sel = FWD_E;
        return sel;
    endfunction

    function automatic logic [1:0] sel_e(input logic [4:0] raddr,
                                         input slot_m_t    m,
                                         input slot_w_t    w);
        logic [1:0] sel;
        sel = FWD_RF;
        if ((w.waddr != 5'd0) && (w.waddr == raddr) && (w.tnew == 3'd0)) sel = FWD_W;
        if ((m.waddr != 5'd0) && (m.waddr == raddr) && (m.tnew == 3'd0)) sel = FWD_M;
        return sel;
    endfunction

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_timer (
        .clk     (clk),
        .reset   (reset),
        .e_md    (slot_e_q.md),
        .md_busy (md_busy)
    );

    always_comb begin
        raw_stall = raw_hazard(d_raddr0, d_tuse0, slot_e_q, slot_m_q) ||
                    raw_hazard(d_raddr1, d_tuse1, slot_e_q, slot_m_q);
        // Both causes share one bubble; they never add up to two
        stall     = raw_stall || (d_md_use && md_busy);

        fwd_d0    = sel_d(d_raddr0, slot_e_q, slot_m_q, slot_w_q);
        fwd_d1    = sel_d(d_raddr1, slot_e_q, slot_m_q, slot_w_q);
        fwd_e0    = sel_e(slot_e_q.raddr0, slot_m_q, slot_w_q);
        fwd_e1    = sel_e(slot_e_q.raddr1, slot_m_q, slot_w_q);
        fwd_m1    = (slot_w_q.waddr != 5'd0) && (slot_w_q.waddr == slot_m_q.raddr1) &&
                    (slot_w_q.tnew == 3'd0);
    end

    // Slot advance: every instruction moves one stage per clock; a stalled
    // D instruction is replaced in E by an all-zero bubble.
    always_comb begin
        slot_e_d = '0;
        if (!stall) begin
            slot_e_d.waddr  = d_waddr;
            slot_e_d.tnew   = tnew_dec(d_tnew);
            slot_e_d.raddr0 = d_raddr0;
            slot_e_d.raddr1 = d_raddr1;
            slot_e_d.md     = d_md_start;
        end

        slot_m_d        = '0;
        slot_m_d.waddr  = slot_e_q.waddr;
        slot_m_d.tnew   = tnew_dec(slot_e_q.tnew);
        slot_m_d.raddr1 = slot_e_q.raddr1;

        slot_w_d        = '0;
        slot_w_d.waddr  = slot_m_q.waddr;
        slot_w_d.tnew   = tnew_dec(slot_m_q.tnew);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_e_q <= '0;
            slot_m_q <= '0;
            slot_w_q <= '0;
        end else begin
            slot_e_q <= slot_e_d;
            slot_m_q <= slot_m_d;
            slot_w_q <= slot_w_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle D instruction vectors with hand-derived expected outputs.
// Latency: expected values are compared on the falling edge of the cycle they were issued in.
// Backpressure: stalled instructions are re-issued explicitly by the vector list.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] d_raddr0, d_raddr1, d_waddr;
    logic [2:0] d_tuse0, d_tuse1, d_tnew;
    logic [1:0] d_md_start;
    logic       d_md_use;
    logic       stall;
    logic [1:0] fwd_d0, fwd_d1, fwd_e0, fwd_e1;
    logic       fwd_m1, md_busy;

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .d_raddr0   (d_raddr0),
        .d_raddr1   (d_raddr1),
        .d_tuse0    (d_tuse0),
        .d_tuse1    (d_tuse1),
        .d_waddr    (d_waddr),
        .d_tnew     (d_tnew),
        .d_md_start (d_md_start),
        .d_md_use   (d_md_use),
        .stall      (stall),
        .fwd_d0     (fwd_d0),
        .fwd_d1     (fwd_d1),
        .fwd_e0     (fwd_e0),
        .fwd_e1     (fwd_e1),
        .fwd_m1     (fwd_m1),
        .md_busy    (md_busy)
    );

    typedef struct packed {
        logic [4:0] raddr0;
        logic [2:0] tuse0;
        logic [4:0] raddr1;
        logic [2:0] tuse1;
        logic [4:0] waddr;
        logic [2:0] tnew;
        logic [1:0] md_start;
        logic       md_use;
    } dins_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] fd0;
        logic [1:0] fd1;
        logic [1:0] fe0;
        logic [1:0] fe1;
        logic       fm1;
        logic       busy;
    } exp_t;

    localparam logic [2:0] NU = 3'd7;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    // Instruction encodings as seen by D (Tnew counted from D, Tuse from D)
    function automatic dins_t i_nop();
        return '{5'd0, NU, 5'd0, NU, 5'd0, 3'd0, 2'd0, 1'b0};
    endfunction
    function automatic dins_t i_alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return '{rs, 3'd1, rt, 3'd1, rd, 3'd2, 2'd0, 1'b0};
    endfunction
    function automatic dins_t i_ori(input logic [4:0] rt, input logic [4:0] rs);
        return '{rs, 3'd1, 5'd0, NU, rt, 3'd2, 2'd0, 1'b0};
    endfunction
    function automatic dins_t i_lw(input logic [4:0] rt, input logic [4:0] rs);
        return '{rs, 3'd1, 5'd0, NU, rt, 3'd3, 2'd0, 1'b0};
    endfunction
    function automatic dins_t i_sw(input logic [4:0] rt, input logic [4:0] rs);
        return '{rs, 3'd1, rt, 3'd2, 5'd0, 3'd0, 2'd0, 1'b0};
    endfunction
    function automatic dins_t i_beq(input logic [4:0] rs, input logic [4:0] rt);
        return '{rs, 3'd0, rt, 3'd0, 5'd0, 3'd0, 2'd0, 1'b0};
    endfunction
    function automatic dins_t i_jal();
        return '{5'd0, NU, 5'd0, NU, 5'd31, 3'd1, 2'd0, 1'b0};
    endfunction
    function automatic dins_t i_jr(input logic [4:0] rs);
        return '{rs, 3'd0, 5'd0, NU, 5'd0, 3'd0, 2'd0, 1'b0};
    endfunction
    function automatic dins_t i_div(input logic [4:0] rs, input logic [4:0] rt);
        return '{rs, 3'd1, rt, 3'd1, 5'd0, 3'd0, 2'd2, 1'b1};
    endfunction
    function automatic dins_t i_mflo(input logic [4:0] rd);
        return '{5'd0, NU, 5'd0, NU, rd, 3'd2, 2'd0, 1'b1};
    endfunction
    function automatic dins_t i_mthi(input logic [4:0] rs);
        return '{rs, 3'd1, 5'd0, NU, 5'd0, 3'd0, 2'd0, 1'b1};
    endfunction

    function automatic exp_t ex(input logic s, input logic [1:0] fd0, input logic [1:0] fd1,
                                input logic [1:0] fe0, input logic [1:0] fe1,
                                input logic fm1, input logic busy);
        return '{s, fd0, fd1, fe0, fe1, fm1, busy};
    endfunction

    task automatic drive(input dins_t d);
        d_raddr0   = d.raddr0;
        d_tuse0    = d.tuse0;
        d_raddr1   = d.raddr1;
        d_tuse1    = d.tuse1;
        d_waddr    = d.waddr;
        d_tnew     = d.tnew;
        d_md_start = d.md_start;
        d_md_use   = d.md_use;
    endtask

    task automatic expect_now(input string nm, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // One D-stage cycle: present the instruction just after the rising edge
    task automatic step(input string nm, input dins_t d, input exp_t e);
        @(posedge clk);
        #1;
        drive(d);
        expect_now(nm, e);
    endtask

    // Monitor: outputs are valid every cycle, so each queued expectation is
    // consumed at the falling edge following its issue.
    exp_t  mon_e, mon_got;
    string mon_nm;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            mon_got = '{stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1, md_busy};
            checks++;
            if (mon_got !== mon_e) begin
                errors++;
                $display("FAIL %s got stall=%0d fd0=%0d fd1=%0d fe0=%0d fe1=%0d fm1=%0d busy=%0d want stall=%0d fd0=%0d fd1=%0d fe0=%0d fe1=%0d fm1=%0d busy=%0d",
                         mon_nm, mon_got.stall, mon_got.fd0, mon_got.fd1, mon_got.fe0, mon_got.fe1,
                         mon_got.fm1, mon_got.busy, mon_e.stall, mon_e.fd0, mon_e.fd1, mon_e.fe0,
                         mon_e.fe1, mon_e.fm1, mon_e.busy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the vector list completed");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive(i_nop());
        step("reset_idle", i_nop(), '0);
        @(negedge clk);
        #1 reset = 1'b1;

        // addu $1 ; subu $2,$1,$3 -> no stall, E takes $1 from M
        step("a_addu",   i_alu(5'd1, 5'd2, 5'd3), '0);
        step("a_subu",   i_alu(5'd2, 5'd1, 5'd3), '0);
        step("a_fwd_e0", i_nop(), ex(1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0));
        step("a_n1",     i_nop(), '0);
        step("a_n2",     i_nop(), '0);

        // lw $4 ; beq $4,$0 -> two stalls, then D takes $4 from W
        step("b_lw",     i_lw(5'd4, 5'd5), '0);
        step("b_stall1", i_beq(5'd4, 5'd0), ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
        step("b_stall2", i_beq(5'd4, 5'd0), ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
        step("b_fwd_d0", i_beq(5'd4, 5'd0), ex(1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
        step("b_n1",     i_nop(), '0);
        step("b_n2",     i_nop(), '0);
        step("b_n3",     i_nop(), '0);

        // lw $6 ; addu $7,$6,$0 -> one stall, then E takes $6 from W
        step("c_lw",     i_lw(5'd6, 5'd5), '0);
        step("c_stall",  i_alu(5'd7, 5'd6, 5'd0), ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
        step("c_go",     i_alu(5'd7, 5'd6, 5'd0), '0);
        step("c_fwd_e0", i_nop(), ex(1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0));
        step("c_n2",     i_nop(), '0);
        step("c_n3",     i_nop(), '0);

        // jal ; jr $31 -> no stall, D takes $31 from E
        step("d_jal",    i_jal(), '0);
        step("d_fwd_d0", i_jr(5'd31), ex(1'b0, 2'd3, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
        step("d_fwd_e0", i_nop(), ex(1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0));
        step("d_n2",     i_nop(), '0);
        step("d_n3",     i_nop(), '0);

        // lw $8 ; sw $8,0($9) -> Tuse 2 hides the load, store data comes from W in M
        step("e_lw",     i_lw(5'd8, 5'd5), '0);
        step("e_sw",     i_sw(5'd8, 5'd9), '0);
        step("e_n1",     i_nop(), '0);
        step("e_fwd_m1", i_nop(), ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0));
        step("e_n3",     i_nop(), '0);

        // ori $0 ; beq $0,$0 -> register 0 never stalls or forwards
        step("f_ori0",   i_ori(5'd0, 5'd5), '0);
        step("f_beq0",   i_beq(5'd0, 5'd0), '0);
        step("f_n1",     i_nop(), '0);
        step("f_n2",     i_nop(), '0);
        step("f_n3",     i_nop(), '0);

        // div ; mflo -> 11 stall cycles, then release
        step("g_div", i_div(5'd5, 5'd6), '0);
        for (int i = 0; i < 11; i++)
            step($sformatf("g_mflo_hold%0d", i), i_mflo(5'd2),
                 ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1));
        step("g_mflo_go", i_mflo(5'd2), '0);

        // div ; mthi $9 -> same 11-cycle hold regardless of registers
        step("h_div", i_div(5'd5, 5'd6), '0);
        for (int i = 0; i < 11; i++)
            step($sformatf("h_mthi_hold%0d", i), i_mthi(5'd9),
                 ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1));
        step("h_mthi_go", i_mthi(5'd9), '0);

        // div ; mflo held until the counter reads 6, then async reset mid-cycle
        step("r_div", i_div(5'd5, 5'd6), '0);
        for (int i = 0; i < 5; i++)
            step($sformatf("r_mflo_hold%0d", i), i_mflo(5'd2),
                 ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        drive(i_mflo(5'd2));
        #2 reset = 1'b0;
        expect_now("r_reset_mid", '0);
        @(negedge clk);
        #1 reset = 1'b1;
        step("r_after_reset", i_mflo(5'd2), '0);
        step("r_n1",          i_nop(), '0);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
